// File: rtl/cordic_info_stage.sv
// One rotation-mode CORDIC micro-rotation, one cycle latency.
// Registers x/y/angle updates plus aligned target/valid/squared sideband.
//
// Ports:
//   clk, rst (async, active-high), clk_en (load enable)
//   target, valid_in, squared_in : sideband travelling with the sample
//   shift_value (i), shift_angle (atan(2^-i))
//   angle, x, y                  : state from the previous stage
//   new_angle, new_x, new_y      : registered updated state
//   target_out, valid_out, squared_out : registered sideband
//
// Optional build macro: CORDIC_STAGE_ROUND_EN
//   defined   : shifted x/y operands are rounded half up for i > 0
//   undefined : plain truncating arithmetic shift
module cordic_info_stage #(
  parameter int DATA_WIDTH       = 22,
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int SHIFT_WIDTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [DATA_WIDTH-1:0]       target,
  input  logic                        valid_in,
  input  logic [FLOAT_DATA_WIDTH-1:0] squared_in,
  input  logic [SHIFT_WIDTH-1:0]      shift_value,
  input  logic [DATA_WIDTH-1:0]       shift_angle,
  input  logic [DATA_WIDTH-1:0]       angle,
  input  logic [DATA_WIDTH-1:0]       x,
  input  logic [DATA_WIDTH-1:0]       y,
  output logic [DATA_WIDTH-1:0]       new_angle,
  output logic [DATA_WIDTH-1:0]       new_x,
  output logic [DATA_WIDTH-1:0]       new_y,
  output logic [DATA_WIDTH-1:0]       target_out,
  output logic                        valid_out,
  output logic [FLOAT_DATA_WIDTH-1:0] squared_out
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       angle;
    logic [DATA_WIDTH-1:0]       x;
    logic [DATA_WIDTH-1:0]       y;
    logic [DATA_WIDTH-1:0]       target;
    logic                        valid;
    logic [FLOAT_DATA_WIDTH-1:0] squared;
  } stage_t;

  stage_t q;
  stage_t q_n;

  logic [DATA_WIDTH-1:0] xs;
  logic [DATA_WIDTH-1:0] ys;
  logic                  d_pos;

  function automatic logic [DATA_WIDTH-1:0] shr(
    input logic [DATA_WIDTH-1:0]  v,
    input logic [SHIFT_WIDTH-1:0] i
  );
    logic [DATA_WIDTH-1:0] r;
`ifdef CORDIC_STAGE_ROUND_EN
    logic [DATA_WIDTH-1:0] rb;
`endif
    r = $unsigned($signed(v) >>> i);
`ifdef CORDIC_STAGE_ROUND_EN
    rb = '0;
    if (i != '0) begin
      // Add back the last bit shifted out: round half up.
      rb[0] = v[i - 1'b1];
    end
    r = r + rb;
`endif
    return r;
  endfunction

  // Equality rotates positively.
  assign d_pos = $signed(target) >= $signed(angle);
  assign xs    = shr(x, shift_value);
  assign ys    = shr(y, shift_value);

  always_comb begin
    q_n         = q;
    q_n.target  = target;
    q_n.valid   = valid_in;
    q_n.squared = squared_in;
    if (d_pos) begin
      q_n.x     = x - ys;
      q_n.y     = y + xs;
      q_n.angle = angle + shift_angle;
    end else begin
      q_n.x     = x + ys;
      q_n.y     = y - xs;
      q_n.angle = angle - shift_angle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clk_en) begin
      q <= q_n;
    end
  end

  assign new_angle   = q.angle;
  assign new_x       = q.x;
  assign new_y       = q.y;
  assign target_out  = q.target;
  assign valid_out   = q.valid;
  assign squared_out = q.squared;

endmodule

// File: tb/tb_cordic_info_stage.sv
// Directed self-checking bench for cordic_info_stage.
// Hand-computed vectors, immediate assertions at each check.
module tb_cordic_info_stage;

  localparam int DW = 22;
  localparam int FW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [DW-1:0] target;
  logic          valid_in;
  logic [FW-1:0] squared_in;
  logic [SW-1:0] shift_value;
  logic [DW-1:0] shift_angle;
  logic [DW-1:0] angle;
  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic [DW-1:0] new_angle;
  logic [DW-1:0] new_x;
  logic [DW-1:0] new_y;
  logic [DW-1:0] target_out;
  logic          valid_out;
  logic [FW-1:0] squared_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cordic_info_stage #(
    .DATA_WIDTH(DW),
    .FLOAT_DATA_WIDTH(FW),
    .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .target(target),
    .valid_in(valid_in),
    .squared_in(squared_in),
    .shift_value(shift_value),
    .shift_angle(shift_angle),
    .angle(angle),
    .x(x),
    .y(y),
    .new_angle(new_angle),
    .new_x(new_x),
    .new_y(new_y),
    .target_out(target_out),
    .valid_out(valid_out),
    .squared_out(squared_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [SW-1:0] i,
                       input logic [DW-1:0] sa,
                       input logic [DW-1:0] xi,
                       input logic [DW-1:0] yi,
                       input logic [DW-1:0] ai,
                       input logic [DW-1:0] ti,
                       input logic          vi,
                       input logic [FW-1:0] si);
    shift_value = i;
    shift_angle = sa;
    x           = xi;
    y           = yi;
    angle       = ai;
    target      = ti;
    valid_in    = vi;
    squared_in  = si;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [DW-1:0] ex,
                         input logic [DW-1:0] ey,
                         input logic [DW-1:0] ea,
                         input logic [DW-1:0] et,
                         input logic          ev,
                         input logic [FW-1:0] es);
    chk({tag, ".x"}, 64'(new_x), 64'(ex));
    chk({tag, ".y"}, 64'(new_y), 64'(ey));
    chk({tag, ".a"}, 64'(new_angle), 64'(ea));
    chk({tag, ".t"}, 64'(target_out), 64'(et));
    chk({tag, ".v"}, 64'(valid_out), 64'(ev));
    chk({tag, ".s"}, 64'(squared_out), 64'(es));
  endtask

  initial begin
    logic [DW-1:0] rnd_x;
    rst    = 1'b1;
    clk_en = 1'b1;
    drive(4'd0, 22'h0C90FD, 22'h09B74E, 22'h0, 22'h0,
          22'h100000, 1'b1, 32'h3F800000);
    #2;
    chk_all("reset", 22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0);
    step();
    chk_all("reset_edge", 22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0);
    rst = 1'b0;

    // d=+1, i=0
    step();
    chk_all("pos_i0", 22'h09B74E, 22'h09B74E, 22'h0C90FD,
            22'h100000, 1'b1, 32'h3F800000);

    // d=-1, target -1.0
    drive(4'd0, 22'h0C90FD, 22'h09B74E, 22'h0, 22'h0,
          22'h300000, 1'b1, 32'h3F800000);
    step();
    chk_all("neg_i0", 22'h09B74E, 22'h3648B2, 22'h336F03,
            22'h300000, 1'b1, 32'h3F800000);

    // i=2, target == angle
    drive(4'd2, 22'h03EB6E, 22'h100000, 22'h040000, 22'h0,
          22'h0, 1'b0, 32'hDEADBEEF);
    step();
    chk_all("eq_i2", 22'h0F0000, 22'h080000, 22'h03EB6E,
            22'h0, 1'b0, 32'hDEADBEEF);

    // negative operand shift, rounding dependent
    drive(4'd1, 22'h076B19, 22'h0, 22'h3FFFFF, 22'h0,
          22'h0, 1'b1, 32'h12345678);
    step();
`ifdef CORDIC_STAGE_ROUND_EN
    chk("sgn_i1.x", 64'(new_x), 64'h0);
`else
    chk("sgn_i1.x", 64'(new_x), 64'h1);
`endif
    chk("sgn_i1.y", 64'(new_y), 64'h3FFFFF);
    chk("sgn_i1.a", 64'(new_angle), 64'h076B19);

    // wraparound: y + x overflows positive range
    drive(4'd0, 22'h1FFFFF, 22'h1FFFFF, 22'h1FFFFF, 22'h100000,
          22'h100000, 1'b1, 32'h0);
    step();
    chk("wrap.x", 64'(new_x), 64'h0);
    chk("wrap.y", 64'(new_y), 64'h3FFFFE);
    chk("wrap.a", 64'(new_angle), 64'h2FFFFF);

    // i=3, shifted-out bits 101 on x, 011 on y; d=-1
    drive(4'd3, 22'h01FD5B, 22'h00002D, 22'h00001B, 22'h000010,
          22'h000000, 1'b1, 32'h0);
    step();
`ifdef CORDIC_STAGE_ROUND_EN
    chk("rnd_i3.x", 64'(new_x), 64'h000030);
    chk("rnd_i3.y", 64'(new_y), 64'h000015);
`else
    chk("rnd_i3.x", 64'(new_x), 64'h000030);
    chk("rnd_i3.y", 64'(new_y), 64'h000016);
`endif
    chk("rnd_i3.a", 64'(new_angle), 64'h3E02B5);

    // hold with clk_en low
    drive(4'd0, 22'h0C90FD, 22'h09B74E, 22'h0, 22'h0,
          22'h100000, 1'b1, 32'h3F800000);
    step();
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rnd_x = DW'($urandom);
      drive(4'd2, 22'h03EB6E, rnd_x, 22'h040000, 22'h0,
            22'h0, 1'b0, 32'hCAFEF00D);
      step();
      chk_all("hold", 22'h09B74E, 22'h09B74E, 22'h0C90FD,
              22'h100000, 1'b1, 32'h3F800000);
    end
    drive(4'd2, 22'h03EB6E, 22'h100000, 22'h040000, 22'h0,
          22'h0, 1'b0, 32'hCAFEF00D);
    clk_en = 1'b1;
    step();
    chk_all("resume", 22'h0F0000, 22'h080000, 22'h03EB6E,
            22'h0, 1'b0, 32'hCAFEF00D);

    // async reset mid-cycle with valid_out high
    drive(4'd0, 22'h0C90FD, 22'h09B74E, 22'h0, 22'h0,
          22'h100000, 1'b1, 32'h3F800000);
    step();
    chk("pre_rst.v", 64'(valid_out), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0);
    step();
    chk_all("rst_hold", 22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    step();
    chk_all("post_rst", 22'h09B74E, 22'h09B74E, 22'h0C90FD,
            22'h100000, 1'b1, 32'h3F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_info_stage.md
CORDIC_INFO_STAGE -- requirements
Module: cordic_info_stage

Interface
REQ-001 Parameter DATA_WIDTH, 22, signed fixed-point word width (Q2.20 two's complement) of target, angle, x, y and shift_angle.
REQ-002 Parameter FLOAT_DATA_WIDTH, 32, width of the squared sideband word.
REQ-003 Parameter SHIFT_WIDTH, 4, width of shift_value.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 clk_en  input  1  stage enable; high = registers load, low = registers hold.
REQ-007 target  input  DATA_WIDTH  target angle travelling with the sample.
REQ-008 valid_in  input  1  sample-valid flag.
REQ-009 squared_in  input  FLOAT_DATA_WIDTH  opaque sideband word travelling with the sample.
REQ-010 shift_value  input  SHIFT_WIDTH  iteration index i (shift amount 0..15).
REQ-011 shift_angle  input  DATA_WIDTH  atan(2^-i) constant for this stage.
REQ-012 angle, x, y  input  DATA_WIDTH each  accumulated angle and vector from the previous stage.
REQ-013 new_angle, new_x, new_y  output  DATA_WIDTH each  registered updated angle and vector.
REQ-014 target_out  output  DATA_WIDTH  registered copy of target.
REQ-015 valid_out  output  1  registered copy of valid_in.
REQ-016 squared_out  output  FLOAT_DATA_WIDTH  registered copy of squared_in, bit-exact.

Function
REQ-017 The stage SHALL perform one rotation-mode CORDIC micro-rotation with exactly one clk cycle of latency; all outputs are registers.
REQ-018 Direction d SHALL be +1 when signed target >= signed angle (equality included), else -1.
REQ-019 d=+1: new_x = x - (y>>>i), new_y = y + (x>>>i), new_angle = angle + shift_angle.
REQ-020 d=-1: new_x = x + (y>>>i), new_y = y - (x>>>i), new_angle = angle - shift_angle.
REQ-021 >>> SHALL be an arithmetic (sign-extending) right shift; i=0 means no shift.
REQ-022 All sums SHALL wrap modulo 2^DATA_WIDTH; no saturation, no overflow flag.
REQ-023 The datapath SHALL update on every enabled cycle regardless of valid_in; valid_out only qualifies the data.
REQ-024 target_out, valid_out, squared_out SHALL be loaded in the same cycle as the datapath, keeping all fields of one sample aligned.
REQ-025 With clk_en low, every output register SHALL hold its value; inputs are ignored.
REQ-026 The stage SHALL contain no state other than its output registers.

Reset
REQ-027 rst high SHALL immediately (no clock edge) clear every output to 0, valid_out included.
REQ-028 rst SHALL override clk_en; a sample in flight at reset is discarded.
REQ-029 After rst falls, the first enabled rising edge SHALL load normally.

Configuration
REQ-030 Macro CORDIC_STAGE_ROUND_EN defined: for i>0, each shifted operand SHALL be (v>>>i) plus bit (i-1) of v (round half up), wrapping; undefined: plain truncating arithmetic shift per REQ-021. Angle path is unaffected either way.

Verification
REQ-031 i=0, shift_angle=0x0C90FD, x=0x09B74E, y=0, angle=0, target=0x100000, valid_in=1, squared_in=0x3F800000 -> next cycle new_x=0x09B74E, new_y=0x09B74E, new_angle=0x0C90FD, target_out=0x100000, valid_out=1, squared_out=0x3F800000.
REQ-032 Same operands with target=0x300000 (-1.0) -> new_x=0x09B74E, new_y=0x3648B2, new_angle=0x336F03.
REQ-033 i=2, shift_angle=0x03EB6E, x=0x100000, y=0x040000, angle=0, target=0 (equal) -> new_x=0x0F0000, new_y=0x080000, new_angle=0x03EB6E.
REQ-034 i=1, x=0, y=0x3FFFFF, angle=0, target=0 -> new_y=0x3FFFFF; new_x=0x000001 without CORDIC_STAGE_ROUND_EN, 0x000000 with it.
REQ-035 Load a sample, drop clk_en for 3 cycles while changing inputs -> outputs unchanged; raise clk_en -> new sample appears after one edge.
REQ-036 Assert rst between clock edges with valid_out=1 -> all outputs 0 before the next edge; hold clk_en high during rst -> outputs stay 0.
